hsid_hsp_feeder: RTL

Write-side front end of the HSID main datapath. It accepts a stream of HSP words from the bus and routes them into the two input FIFOs consumed by the main FSM. The first HSP of each run goes to the captured-pixel FIFO, then `hsp_library_size` library HSPs go to the reference FIFO. It generates `fifo_captured_complete` and applies back-pressure from both FIFOs' full flags.

---
 rtl/hsid_pkg.sv | 15 +
 rtl/hsid_band_pack_counter.sv | 47 ++++
 rtl/hsid_hsp_feeder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hsid_pkg.sv
// Shared HSID constants and types for the main datapath front end.
package hsid_pkg;

    localparam int unsigned HSID_WORD_WIDTH        = 32;
    localparam int unsigned HSID_HSP_BANDS_WIDTH   = 8;
    localparam int unsigned HSID_HSP_LIBRARY_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        LOAD_CAPTURED = 2'd1,
        LOAD_REF      = 2'd2,
        DONE          = 2'd3
    } hsid_feeder_state_t;

endpackage

// File: rtl/hsid_band_pack_counter.sv
// Two-level counter: band pack within an HSP, and HSP within the reference library.
module hsid_band_pack_counter #(
    parameter int unsigned BANDS_WIDTH   = 8,
    parameter int unsigned LIBRARY_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    input  logic                     hsp_en,
    input  logic [BANDS_WIDTH-1:0]   threshold,
    input  logic [LIBRARY_WIDTH-1:0] size,
    output logic [BANDS_WIDTH-1:0]   pack_count,
    output logic [LIBRARY_WIDTH-1:0] hsp_count,
    output logic                     pack_last,
    output logic                     all_last
);

    logic [BANDS_WIDTH-1:0]   r_pack_count;
    logic [LIBRARY_WIDTH-1:0] r_hsp_count;

    // Zero threshold/size never reach here, so the -1 cannot wrap.
    assign pack_last  = (r_pack_count == (threshold - BANDS_WIDTH'(1)));
    assign all_last   = pack_last && (r_hsp_count == (size - LIBRARY_WIDTH'(1)));
    assign pack_count = r_pack_count;
    assign hsp_count  = r_hsp_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack_count <= '0;
            r_hsp_count  <= '0;
        end else if (clr) begin
            r_pack_count <= '0;
            r_hsp_count  <= '0;
        end else if (inc) begin
            if (pack_last) begin
                r_pack_count <= '0;
                if (hsp_en) begin
                    r_hsp_count <= all_last ? '0 : r_hsp_count + LIBRARY_WIDTH'(1);
                end
            end else begin
                r_pack_count <= r_pack_count + BANDS_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/hsid_hsp_feeder.sv
// Steers the incoming HSP word stream into the captured and reference FIFOs,
// with back-pressure from both full flags.
module hsid_hsp_feeder
    import hsid_pkg::*;
#(
    parameter int unsigned WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int unsigned HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int unsigned HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size,
    input  logic [HSP_BANDS_WIDTH-1:0]   band_pack_threshold,
    input  logic [WORD_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [WORD_WIDTH-1:0]        fifo_captured_data,
    output logic                         fifo_captured_wr_en,
    input  logic                         fifo_captured_full,
    output logic                         fifo_captured_complete,
    output logic [WORD_WIDTH-1:0]        fifo_ref_data,
    output logic                         fifo_ref_wr_en,
    input  logic                         fifo_ref_full,
    output hsid_feeder_state_t           state,
    output logic [HSP_BANDS_WIDTH-1:0]   band_pack_count,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref_count,
    output logic                         cfg_error,
    output logic                         done,
    output logic                         idle
);

    hsid_feeder_state_t           r_state;
    logic [HSP_BANDS_WIDTH-1:0]   r_threshold;
    logic [HSP_LIBRARY_WIDTH-1:0] r_size;
    logic                         r_complete;
    logic                         r_cfg_error;

    logic w_s_ready;
    logic w_xfer;
    logic w_pack_last;
    logic w_all_last;
    logic w_cnt_clr;
    logic w_cfg_ok;

    // Ready follows the full flag of the FIFO owned by the current state; clear blocks writes.
    always_comb begin
        w_s_ready = 1'b0;
        if (!clear) begin
            case (r_state)
                LOAD_CAPTURED: w_s_ready = !fifo_captured_full;
                LOAD_REF:      w_s_ready = !fifo_ref_full;
                default:       w_s_ready = 1'b0;
            endcase
        end
    end

    assign w_xfer    = s_valid && w_s_ready;
    assign w_cnt_clr = clear || (r_state == DONE);
    assign w_cfg_ok  = (band_pack_threshold != '0) && (hsp_library_size != '0);

    hsid_band_pack_counter #(
        .BANDS_WIDTH   (HSP_BANDS_WIDTH),
        .LIBRARY_WIDTH (HSP_LIBRARY_WIDTH)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_cnt_clr),
        .inc        (w_xfer),
        .hsp_en     (r_state == LOAD_REF),
        .threshold  (r_threshold),
        .size       (r_size),
        .pack_count (band_pack_count),
        .hsp_count  (hsp_ref_count),
        .pack_last  (w_pack_last),
        .all_last   (w_all_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_threshold <= '0;
            r_size      <= '0;
            r_complete  <= 1'b0;
            r_cfg_error <= 1'b0;
        end else begin
            r_cfg_error <= 1'b0;
            if (clear) begin
                r_state    <= IDLE;
                r_complete <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (w_cfg_ok) begin
                                r_threshold <= band_pack_threshold;
                                r_size      <= hsp_library_size;
                                r_complete  <= 1'b0;
                                r_state     <= LOAD_CAPTURED;
                            end else begin
                                r_cfg_error <= 1'b1;
                                r_state     <= DONE;
                            end
                        end
                    end
                    LOAD_CAPTURED: begin
                        if (w_xfer && w_pack_last) begin
                            r_complete <= 1'b1;
                            r_state    <= LOAD_REF;
                        end
                    end
                    LOAD_REF: begin
                        if (w_xfer && w_all_last) begin
                            r_state <= DONE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign s_ready                = w_s_ready;
    assign fifo_captured_data     = s_data;
    assign fifo_ref_data          = s_data;
    assign fifo_captured_wr_en    = w_xfer && (r_state == LOAD_CAPTURED);
    assign fifo_ref_wr_en         = w_xfer && (r_state == LOAD_REF);
    assign fifo_captured_complete = r_complete;
    assign state                  = r_state;
    assign cfg_error              = r_cfg_error;
    assign done                   = (r_state == DONE);
    assign idle                   = (r_state == IDLE);

endmodule
